// File: rtl/if_id_buffer.sv
// if_id_buffer: first-word-fall-through instruction queue between fetch and decode.
// It holds each fetched word with its PC and a misaligned flag, and presents the
// oldest entry with a valid/ready handshake. A redirect (flush) empties the queue.
module if_id_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instruction_in,
  input  logic [31:0]              pc_in,
  input  logic                     valid,
  input  logic                     flush,
  input  logic                     ready_in,
  output logic [31:0]              instruction_out,
  output logic [31:0]              pc_out,
  output logic [31:0]              pc4_out,
  output logic                     misaligned_out,
  output logic                     valid_out,
  output logic                     full_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic          mis_mem   [DEPTH];

  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;

  logic          empty;
  logic          push;
  logic          pop;

  // Handshake decode; full and empty come from the registered count only.
  always_comb begin
    empty     = (count == '0);
    full_out  = (count == CW'(DEPTH));
    valid_out = ~empty & ~flush;
    push      = valid & ~full_out & ~flush;
    pop       = valid_out & ready_in & ~flush;
    count_out = count;
  end

  // Entry storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wp] <= instruction_in;
      pc_mem[wp]    <= pc_in;
      mis_mem[wp]   <= (pc_in[1:0] != 2'b00);
    end
  end

  // Pointers and occupancy; flush clears everything and outranks push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + AW'(1);
      end
      if (pop) begin
        rp <= rp + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // Head entry falls through from storage; empty queue shows the NOP defaults.
  always_comb begin
    instruction_out = NOP;
    pc_out          = 32'h0000_0000;
    misaligned_out  = 1'b0;
    if (!empty) begin
      instruction_out = instr_mem[rp];
      pc_out          = pc_mem[rp];
      misaligned_out  = mis_mem[rp];
    end
    pc4_out = pc_out + 32'd4;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

First-word-fall-through instruction queue between the fetch stage and decode. Captures each instruction word returned by instruction memory together with its PC, and presents the oldest entry to decode with a valid/ready handshake. Back-pressures fetch when full and discards all wrong-path entries on a branch or jump redirect. The queue is DEPTH entries deep and absorbs one-cycle decode stalls without losing fetched words.

## Interface

Parameters:
- DEPTH, 2: number of entries; power of two, ≥2.
- NOP, 32'h0000_0013: word driven on instruction_out when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- instruction_in  input  32  instruction word from instruction memory.
- pc_in  input  32  PC of instruction_in (fetch address_out, aligned to the returning word).
- valid  input  1  instruction_in/pc_in carry a real fetched word this cycle.
- flush  input  1  redirect (taken Branch, Jal or Jalr) from execute; kills all queued and incoming words.
- ready_in  input  1  decode accepts the head entry this cycle.
- instruction_out  output  32  head instruction; NOP when empty.
- pc_out  output  32  head PC; 0 when empty.
- pc4_out  output  32  pc_out + 4, modulo 2^32; 4 when empty.
- misaligned_out  output  1  head entry's pc had bits [1:0] ≠ 0; 0 when empty.
- valid_out  output  1  head entry is valid.
- full_out  output  1  count == DEPTH; fetch must hold its PC and mem_request result.
- count_out  output  $clog2(DEPTH)+1  number of occupied entries.

## Operation

- Storage: DEPTH × {instr[31:0], pc[31:0], misaligned}, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrap naturally), count register.
- push = valid & ~full_out & ~flush. Writes {instruction_in, pc_in, pc_in[1:0]≠0} at wp; wp increments.
- pop = valid_out & ready_in & ~flush. rp increments.
- count: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- valid is ignored when full_out is asserted; the word is not written. Fetch must re-present it; full_out is its stall.
- A push while full is refused even if a pop occurs in the same cycle, because full_out is derived from registered count.
- A push while empty with a simultaneous ready_in has no effect on the output. The word appears on the outputs the next cycle; there is no bypass.
- flush has priority over everything. In the flush cycle, valid_out is forced to 0 combinationally. At the next edge: wp = rp = 0, count = 0, and any incoming valid word is dropped.
- The head entry drives the outputs directly from storage at rp (first-word fall-through).
- valid_out = (count ≠ 0) & ~flush.
- When count = 0, outputs show the NOP / 0 / 4 / 0 defaults.
- Storage contents are not required to be reset. Only the pointers and count are reset.

## Timing

- Reset (rst=0, asynchronous): wp=0, rp=0, count=0. Outputs immediately become instruction_out=NOP, pc_out=0, pc4_out=4, misaligned_out=0, valid_out=0, full_out=0, count_out=0.
- Reset deassertion is taken synchronously by the integrator. The first push can occur on the first edge with rst=1.
- Latency from input to output: 1 cycle. A word pushed at edge N is visible on the outputs after edge N.
- Throughput: 1 word/cycle sustained when ready_in=1 every cycle; count stays at 1.
- full_out and valid_out are valid combinationally within the cycle and have no edge-to-output lag beyond the registered count.
- Reset asserted mid-operation discards all entries at once, regardless of flush, valid or ready_in.

## Test plan

- Reset: hold rst=0 with valid=1 and instruction_in=32'hDEADBEEF. Expect valid_out=0, instruction_out=32'h00000013, pc4_out=4, count_out=0 throughout.
- Streaming: push pc 0x0, 0x4, 0x8 (instr 0x00500093, 0x00A00113, 0x002081B3) with ready_in=1. Expect each word on the outputs one cycle later in order, pc4_out = 0x4, 0x8, 0xC, and count_out stays at 1.
- Fill/backpressure: ready_in=0, push 3 words with DEPTH=2. Expect full_out=1 after 2 pushes and the third word absent. Then ready_in=1 for one cycle: pops word 0; full_out drops; re-presented third word accepted next cycle.
- Flush: queue holds 2 entries and flush=1 with valid=1 (pc 0x40). Expect valid_out=0 in that cycle, and count_out=0, valid_out=0 the following cycle (pc 0x40 not stored). Then push pc 0x100 and expect it at the head.
- Misaligned/wrap: push pc 0x2 and expect misaligned_out=1. Push pc 0xFFFFFFFC and expect pc4_out=0x00000000. Run 10 push/pop pairs to cross pointer wrap; expect the order preserved.
- Async reset mid-operation: with 2 entries queued, pulse rst low between edges. Expect outputs to return to defaults before the next edge, and no stale entry afterwards.
